pru_cmd_encoder: RTL and testbench

- Transmit side of the PRU command interface: accepts shape/palette commands as parallel fields and packs each into the two-word 32-bit format decoded by the PRU preprocessor.
- Emits the two words as write-strobed transfers, then throttles on PRU done.
- Sits between the host/bus command source and the preprocessor, decoupled by a small command FIFO.

---
 rtl/pru_cmd_encoder.sv | 158 +++++++++++++++
 tb/tb_pru_cmd_encoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pru_cmd_encoder.sv
// rtl/pru_cmd_encoder.sv - packs queued PRU commands into two strobed 32-bit words.
// Optional clip rejection of out-of-range draw commands: define PRU_CLIP_CHECK_EN.
module pru_cmd_encoder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 65535,
  parameter int MAX_ROW = 639,
  parameter int MAX_COL = 479
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_row,
  input  logic [8:0]  cmd_col,
  input  logic [9:0]  cmd_width,
  input  logic [8:0]  cmd_height_radius,
  input  logic [1:0]  cmd_shape,
  input  logic [1:0]  cmd_color,
  input  logic        cmd_subtract,
  input  logic        cmd_color_load,
  input  logic        pru_done,
  output logic [31:0] data,
  output logic        write,
  output logic        idle,
  output logic        timeout_err,
  output logic        clip_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = 44;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMAX  = {TW{1'b1}};

  typedef enum logic [2:0] {IDLE, W0, GAP, W1, WAIT_DONE} state_t;

  // Entry layout: row, col, width, height_radius, shape, color, subtract, color_load
  function automatic logic [31:0] pack_w0(input logic [CW-1:0] e);
    return {1'b0, e[43:34], e[33:25], e[24:15], e[3:2]};
  endfunction

  function automatic logic [31:0] pack_w1(input logic [CW-1:0] e);
    return {16'h0000, e[0], e[1], 2'b00, ~e[0], e[5:4], e[14:6]};
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   mem_q [DEPTH];
  logic [CW-1:0]   mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic [31:0]     data_q, data_d, w1_q, w1_d;
  logic            write_q, write_d, idle_q, idle_d;
  logic            timeout_err_q, timeout_err_d, clip_err_q, clip_err_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   cmd_in, head;
  logic            pop, accept, clip_hit;

  assign cmd_in = {cmd_row, cmd_col, cmd_width, cmd_height_radius,
                   cmd_shape, cmd_color, cmd_subtract, cmd_color_load};
  assign head   = mem_q[rd_ptr_q];
  assign pop    = (state_q == IDLE) && (count_q != '0);
  // A pop in the same cycle frees a slot, so a full FIFO may still accept.
  assign cmd_ready = !rst && ((count_q != (PW+1)'(DEPTH)) || pop);
  assign accept    = cmd_valid && cmd_ready;

`ifdef PRU_CLIP_CHECK_EN
  localparam logic [9:0] MAX_ROW_L = MAX_ROW[9:0];
  localparam logic [8:0] MAX_COL_L = MAX_COL[8:0];
  assign clip_hit = !head[0] && ((head[43:34] > MAX_ROW_L) || (head[33:25] > MAX_COL_L));
`else
  assign clip_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pop && !clip_hit) state_d = W0;
      W0:        state_d = GAP;
      GAP:       state_d = W1;
      W1:        state_d = w1_q[11] ? WAIT_DONE : IDLE;
      WAIT_DONE: if (pru_done || timer_q == TLAST) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    data_d        = data_q;
    w1_d          = w1_q;
    timer_d       = timer_q;
    timeout_err_d = timeout_err_q;
    clip_err_d    = clip_err_q | (pop && clip_hit);
    if (accept) begin
      mem_d[wr_ptr_q] = cmd_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (PW+1)'(accept) - (PW+1)'(pop);
    if (pop && !clip_hit) begin
      data_d = pack_w0(head);
      w1_d   = pack_w1(head);
    end
    if (state_q == GAP) data_d = w1_q;
    if (state_q == W1) timer_d = '0;
    if (state_q == WAIT_DONE) begin
      if (timer_q != TMAX) timer_d = timer_q + 1'b1;
      if (!pru_done && timer_q == TLAST) timeout_err_d = 1'b1;
    end
    // Strobe trails the state by one cycle so data is always set up first.
    write_d = (state_q == W0) || (state_q == W1);
    idle_d  = (state_q == IDLE) && (count_d == '0);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      data_q        <= '0;
      w1_q          <= '0;
      write_q       <= 1'b0;
      idle_q        <= 1'b1;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
      clip_err_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      data_q        <= data_d;
      w1_q          <= w1_d;
      write_q       <= write_d;
      idle_q        <= idle_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
      clip_err_q    <= clip_err_d;
    end
  end

  assign data        = data_q;
  assign write       = write_q;
  assign idle        = idle_q;
  assign timeout_err = timeout_err_q;
  assign clip_err    = clip_err_q;

endmodule

// File: tb/tb_pru_cmd_encoder.sv
// tb/tb_pru_cmd_encoder.sv - directed vector bench for pru_cmd_encoder.
module tb_pru_cmd_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_row;
  logic [8:0]  cmd_col;
  logic [9:0]  cmd_width;
  logic [8:0]  cmd_height_radius;
  logic [1:0]  cmd_shape;
  logic [1:0]  cmd_color;
  logic        cmd_subtract;
  logic        cmd_color_load;
  logic        pru_done;
  logic [31:0] data;
  logic        write;
  logic        idle;
  logic        timeout_err;
  logic        clip_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pru_cmd_encoder #(.DEPTH(4), .TIMEOUT(16), .MAX_ROW(639), .MAX_COL(479)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_width(cmd_width),
    .cmd_height_radius(cmd_height_radius), .cmd_shape(cmd_shape),
    .cmd_color(cmd_color), .cmd_subtract(cmd_subtract),
    .cmd_color_load(cmd_color_load), .pru_done(pru_done), .data(data),
    .write(write), .idle(idle), .timeout_err(timeout_err), .clip_err(clip_err)
  );

  typedef struct {
    logic [9:0]  row;
    logic [8:0]  col;
    logic [9:0]  width;
    logic [8:0]  hr;
    logic [1:0]  shape;
    logic [1:0]  color;
    logic        sub;
    logic        cl;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vt [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    cmd_row = v.row; cmd_col = v.col; cmd_width = v.width;
    cmd_height_radius = v.hr; cmd_shape = v.shape; cmd_color = v.color;
    cmd_subtract = v.sub; cmd_color_load = v.cl;
  endtask

  initial begin
    //        row   col   width  hr    shp  col  sub  cl    word0          word1
    vt[0] = '{10'd15,   9'd10,  10'd10,   9'd15,  2'd0, 2'd1, 1'b0, 1'b0, 32'h01E0A029, 32'h0000080F};
    vt[1] = '{10'd0,    9'd0,   10'd0,    9'd0,   2'd0, 2'd0, 1'b0, 1'b1, 32'h00000000, 32'h00008000};
    vt[2] = '{10'd639,  9'd479, 10'd0,    9'd511, 2'd1, 2'd3, 1'b1, 1'b0, 32'h4FFDF003, 32'h00004BFF};
    vt[3] = '{10'd1023, 9'd511, 10'd1023, 9'd511, 2'd3, 2'd3, 1'b1, 1'b1, 32'h7FFFFFFF, 32'h0000C7FF};
    vt[4] = '{10'd0,    9'd0,   10'h2AA,  9'd0,   2'd2, 2'd0, 1'b0, 1'b0, 32'h00000AA8, 32'h00000C00};

    rst = 1'b1; cmd_valid = 1'b0; pru_done = 1'b0;
    drive(vt[1]);
    #1;
    chk("ready_in_reset", 32'(cmd_ready), 32'd0);
    tick(); tick();
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_clip_err", 32'(clip_err), 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Single-command latency and packing for every vector
    for (int i = 0; i < 5; i++) begin
      drive(vt[i]); cmd_valid = 1'b1;
      tick(); cmd_valid = 1'b0;
      chk($sformatf("v%0d_c0_idle", i), 32'(idle), 32'd0);
      tick(); chk($sformatf("v%0d_c1_write", i), 32'(write), 32'd0);
      tick(); chk($sformatf("v%0d_c2_write", i), 32'(write), 32'd1);
      chk($sformatf("v%0d_word0", i), data, vt[i].w0);
      tick(); chk($sformatf("v%0d_c3_write", i), 32'(write), 32'd0);
      tick(); chk($sformatf("v%0d_c4_write", i), 32'(write), 32'd1);
      chk($sformatf("v%0d_word1", i), data, vt[i].w1);
      tick(); chk($sformatf("v%0d_c5_write", i), 32'(write), 32'd0);
      chk($sformatf("v%0d_c5_hold", i), data, vt[i].w1);
      chk($sformatf("v%0d_c5_idle", i), 32'(idle), vt[i].cl ? 32'd1 : 32'd0);
      if (!vt[i].cl) begin
        pru_done = 1'b1; tick(); pru_done = 1'b0;
        chk($sformatf("v%0d_c6_idle", i), 32'(idle), 32'd0);
        tick(); chk($sformatf("v%0d_c7_idle", i), 32'(idle), 32'd1);
      end
    end

    // Stray pru_done while idle must be ignored
    pru_done = 1'b1; tick(); pru_done = 1'b0; tick();
    chk("stray_done_write", 32'(write), 32'd0);
    chk("stray_done_idle", 32'(idle), 32'd1);

    // Fill the FIFO behind a command stuck in WAIT_DONE, then release it
    drive(vt[0]); cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    for (int k = 0; k < 4; k++) begin
      drive(vt[(k == 0) ? 2 : (k == 1) ? 3 : 4]); cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    chk("full_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("full_ready_hold", 32'(cmd_ready), 32'd0);
    pru_done = 1'b1; tick(); pru_done = 1'b0;
    chk("ready_on_pop", 32'(cmd_ready), 32'd1);
    tick(); chk("ready_after_pop", 32'(cmd_ready), 32'd1);
    tick(); chk("q2_w0_write", 32'(write), 32'd1);
    chk("q2_word0", data, vt[2].w0);
    tick(); tick(); chk("q2_w1_write", 32'(write), 32'd1);
    chk("q2_word1", data, vt[2].w1);

    // No pru_done: timeout exactly 16 cycles after the word1 strobe
    for (int c = 1; c <= 15; c++) tick();
    chk("timeout_not_yet", 32'(timeout_err), 32'd0);
    tick(); chk("timeout_set", 32'(timeout_err), 32'd1);
    tick(); tick(); chk("q3_w0_write", 32'(write), 32'd1);
    chk("q3_word0", data, vt[3].w0);
    tick(); tick(); tick(); chk("timeout_sticky", 32'(timeout_err), 32'd1);

    // Reset during GAP with a second command queued
    rst = 1'b1; tick(); rst = 1'b0;
    drive(vt[0]); cmd_valid = 1'b1; tick(); drive(vt[4]); tick(); cmd_valid = 1'b0;
    tick();
    rst = 1'b1; #1;
    chk("gap_rst_ready", 32'(cmd_ready), 32'd0);
    tick(); rst = 1'b0;
    chk("gap_rst_write", 32'(write), 32'd0);
    chk("gap_rst_data", data, 32'd0);
    chk("gap_rst_idle", 32'(idle), 32'd1);
    chk("gap_rst_timeout_clr", 32'(timeout_err), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick(); chk("gap_rst_quiet", 32'(write) | 32'(!idle), 32'd0);
    end
    drive(vt[4]); cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
    tick(); tick(); chk("post_rst_w0", data, vt[4].w0);
    chk("post_rst_w0_write", 32'(write), 32'd1);
    tick(); tick(); chk("post_rst_w1", data, vt[4].w1);
    pru_done = 1'b1; tick(); pru_done = 1'b0; tick(); tick();

`ifdef PRU_CLIP_CHECK_EN
    begin
      vec_t bad;
      int wr_seen;
      bad = vt[0]; bad.row = 10'd700;
      drive(bad); cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
      wr_seen = 0;
      for (int c = 1; c <= 6; c++) begin
        tick(); if (write) wr_seen++;
      end
      chk("clip_no_write", 32'(wr_seen), 32'd0);
      chk("clip_err_set", 32'(clip_err), 32'd1);
      drive(vt[0]); cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
      tick(); tick(); chk("clip_next_w0", data, vt[0].w0);
      tick(); tick(); chk("clip_next_w1", data, vt[0].w1);
      chk("clip_err_sticky", 32'(clip_err), 32'd1);
    end
`else
    chk("clip_err_tied", 32'(clip_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
